// File: rtl/mixer_multichan_if.sv
// ZX-Uno register bus seen by the multichannel mixer.
// master: CPU side (addr, strobes, din); slave: mixer (dout, oe_n).
interface mixer_multichan_if;
   logic [7:0] zxuno_addr;
   logic       zxuno_regrd;
   logic       zxuno_regwr;
   logic [7:0] din;
   logic [7:0] dout;
   logic       oe_n;

   modport master (
      output zxuno_addr, zxuno_regrd, zxuno_regwr, din,
      input  dout, oe_n
   );

   modport slave (
      input  zxuno_addr, zxuno_regrd, zxuno_regwr, din,
      output dout, oe_n
   );
endinterface

// File: rtl/mixer_multichan.sv
// NCHAN-channel audio mixer: per-channel volume/mute registers,
// one-channel-per-clock MAC, output saturation and 1-bit sigma-delta DAC.
// Ports: clk, rst_n (sync, active low); bus (ZX-Uno regs, slave);
//   ch_in (NCHAN packed samples), sample_tick (frame start);
//   mix_out/mix_valid (last mix + update pulse); audio_out (bitstream).
module mixer_multichan #(
   parameter int         NCHAN   = 4,
   parameter int         WIDTH   = 8,
   parameter int         VOLBITS = 4,
   parameter logic [7:0] REGBASE = 8'hF8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mixer_multichan_if.slave       bus,
   input  logic [NCHAN*WIDTH-1:0] ch_in,
   input  logic                   sample_tick,
   output logic [WIDTH-1:0]       mix_out,
   output logic                   mix_valid,
   output logic                   audio_out
);

   localparam int         IW  = $clog2(NCHAN);
   localparam int         PW  = WIDTH + VOLBITS;
   localparam int         AW  = PW + IW;
   localparam logic [7:0] NC8 = 8'(NCHAN);

   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

   state_t state_q, state_d;

   logic [VOLBITS-1:0] vol_q  [NCHAN];
   logic               mute_q [NCHAN];
   logic               overrun_q;

   logic [WIDTH-1:0]   ch_s   [NCHAN];
   logic [VOLBITS-1:0] vol_s  [NCHAN];
   logic               mute_s [NCHAN];
   logic [IW-1:0]      idx_q;
   logic [AW-1:0]      acc_q;
   logic [WIDTH:0]     sd_q;

   logic [7:0]       off;
   logic             in_rng;
   logic             sel_st;
   logic             st_wr;
   logic [IW-1:0]    ci;
   logic [7:0]       rd_ch;

   logic             tick_go;
   logic             ovr_set;
   logic             mix_load;
   logic [PW-1:0]    term;
   logic [WIDTH-1:0] sat_v;

   // only din[7] and the volume field are stored
   wire unused_din = ^bus.din;

   // ---------------- register file ----------------
   assign off    = bus.zxuno_addr - REGBASE;
   assign in_rng = (bus.zxuno_addr >= REGBASE) && (off <= NC8);
   assign sel_st = (off == NC8);
   assign st_wr  = bus.zxuno_regwr && (bus.zxuno_addr == REGBASE + NC8);
   assign ci     = off[IW-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NCHAN; i++) begin
            vol_q[i]  <= '1;
            mute_q[i] <= 1'b0;
         end
      end else if (bus.zxuno_regwr) begin
         for (int i = 0; i < NCHAN; i++) begin
            if (bus.zxuno_addr == REGBASE + 8'(i)) begin
               mute_q[i] <= bus.din[7];
               vol_q[i]  <= bus.din[VOLBITS-1:0];
            end
         end
      end
   end

   // a tick landing with a status write wins: the overrun stays visible
   always_ff @(posedge clk) begin
      if (!rst_n)       overrun_q <= 1'b0;
      else if (ovr_set) overrun_q <= 1'b1;
      else if (st_wr)   overrun_q <= 1'b0;
   end

   always_comb begin
      rd_ch              = '0;
      rd_ch[7]           = mute_q[ci];
      rd_ch[VOLBITS-1:0] = vol_q[ci];
   end

   always_comb begin
      bus.dout = 8'h00;
      bus.oe_n = 1'b1;
      if (bus.zxuno_regrd && in_rng) begin
         bus.oe_n = 1'b0;
         bus.dout = sel_st ? {7'b0, overrun_q} : rd_ch;
      end
   end

   // ---------------- frame FSM ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (sample_tick) state_d = ACC;
         ACC:     if (idx_q == IW'(NCHAN - 1)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      tick_go  = (state_q == IDLE) && sample_tick;
      ovr_set  = (state_q != IDLE) && sample_tick;
      mix_load = (state_q == DONE);
      term     = mute_s[idx_q] ? '0
               : PW'(ch_s[idx_q]) * PW'(vol_s[idx_q]);
      // acc>>VOLBITS overflows WIDTH iff any bit above PW-1 is set
      sat_v    = (|acc_q[AW-1:PW]) ? '1 : acc_q[PW-1:VOLBITS];
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx_q     <= '0;
         acc_q     <= '0;
         mix_out   <= '0;
         mix_valid <= 1'b0;
         sd_q      <= '0;
         for (int i = 0; i < NCHAN; i++) begin
            ch_s[i]   <= '0;
            vol_s[i]  <= '0;
            mute_s[i] <= 1'b0;
         end
      end else begin
         mix_valid <= mix_load;
         if (tick_go) begin
            acc_q <= '0;
            idx_q <= '0;
            for (int i = 0; i < NCHAN; i++) begin
               ch_s[i]   <= ch_in[i*WIDTH +: WIDTH];
               vol_s[i]  <= vol_q[i];
               mute_s[i] <= mute_q[i];
            end
         end else if (state_q == ACC) begin
            acc_q <= acc_q + AW'(term);
            idx_q <= idx_q + 1'b1;
         end
         if (mix_load) mix_out <= sat_v;
         sd_q <= {1'b0, sd_q[WIDTH-1:0]} + {1'b0, mix_out};
      end
   end

   assign audio_out = sd_q[WIDTH];

endmodule

// File: tb/tb_mixer_multichan.sv
// Scoreboard bench for mixer_multichan (NCHAN=4, WIDTH=8, VOLBITS=4).
// Registers, latency, saturation, mute/snapshot, overrun, DAC, reset.
module tb_mixer_multichan;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] ch_in;
   logic        sample_tick;
   logic [7:0]  mix_out;
   logic        mix_valid;
   logic        audio_out;

   mixer_multichan_if bus();

   mixer_multichan #(
      .NCHAN(4), .WIDTH(8), .VOLBITS(4), .REGBASE(8'hF8)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .ch_in(ch_in),
      .sample_tick(sample_tick),
      .mix_out(mix_out),
      .mix_valid(mix_valid),
      .audio_out(audio_out)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] mix;
      int         cyc;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         checks = 0;
   int         fails  = 0;
   int         cyc    = 0;
   int         nvalid = 0;
   logic [3:0] vol_m [4];
   logic       mute_m [4];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (mix_valid) begin
         nvalid++;
         if (q.size() == 0) begin
            chk("unexp_valid", 32'(mix_valid), 32'd0);
         end else begin
            e = q.pop_front();
            chk("mix", 32'(mix_out), 32'(e.mix));
            chk("lat", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   function automatic logic [7:0] mix_model();
      int s = 0;
      for (int i = 0; i < 4; i++)
         if (!mute_m[i])
            s += int'(ch_in[i*8 +: 8]) * int'(vol_m[i]);
      s = s >> 4;
      return (s > 255) ? 8'hFF : 8'(s);
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         vol_m[i]  = 4'hF;
         mute_m[i] = 1'b0;
      end
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus.zxuno_addr  = a;
      bus.din         = d;
      bus.zxuno_regwr = 1'b1;
      step();
      bus.zxuno_regwr = 1'b0;
      if (a >= 8'hF8 && a <= 8'hFB) begin
         mute_m[a - 8'hF8] = d[7];
         vol_m[a - 8'hF8]  = d[3:0];
      end
   endtask

   task automatic rd(input string tag, input logic [7:0] a,
                     input logic eoe, input logic [7:0] ed);
      bus.zxuno_addr  = a;
      bus.zxuno_regrd = 1'b1;
      #1;
      chk({tag, "_oe"}, 32'(bus.oe_n), 32'(eoe));
      chk({tag, "_d"}, 32'(bus.dout), 32'(ed));
      bus.zxuno_regrd = 1'b0;
   endtask

   // tick sampled at the next edge E0; valid seen after E(NCHAN+1)
   task automatic send_tick(input bit expect_mix);
      exp_t x;
      if (expect_mix) begin
         x.mix = mix_model();
         x.cyc = cyc + 6;
         q.push_back(x);
      end
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) step();
      chk("drain", 32'(q.size()), 32'd0);
   endtask

   task automatic count_ones(input string tag, input int exp);
      int n = 0;
      repeat (6) step();
      repeat (256) begin
         @(negedge clk);
         n += int'(audio_out);
      end
      chk(tag, 32'(n), 32'(exp));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      int nv;
      rst_n           = 1'b0;
      ch_in           = '0;
      sample_tick     = 1'b0;
      bus.zxuno_addr  = 8'h00;
      bus.zxuno_regrd = 1'b0;
      bus.zxuno_regwr = 1'b0;
      bus.din         = 8'h00;
      model_reset();
      repeat (3) step();
      rst_n = 1'b1;
      step();

      // reset state
      for (int i = 0; i < 4; i++)
         rd("rst_vol", 8'hF8 + 8'(i), 1'b0, 8'h0F);
      rd("rst_st", 8'hFC, 1'b0, 8'h00);
      rd("out_rng", 8'hF7, 1'b1, 8'h00);
      chk("rst_mix", 32'(mix_out), 32'h00);
      chk("rst_aud", 32'(audio_out), 32'd0);
      chk("rst_val", 32'(mix_valid), 32'd0);

      // basic mix
      ch_in = {8'h00, 8'h00, 8'h40, 8'h40};
      send_tick(1);
      drain();
      chk("t2_mix", 32'(mix_out), 32'h78);

      // saturation
      ch_in = 32'hFFFF_FFFF;
      send_tick(1);
      drain();
      chk("sat_f", 32'(mix_out), 32'hFF);
      for (int i = 0; i < 4; i++) wr(8'hF8 + 8'(i), 8'h08);
      send_tick(1);
      drain();
      chk("sat_8", 32'(mix_out), 32'hFF);
      ch_in = 32'h0000_00FF;
      send_tick(1);
      drain();
      chk("one_8", 32'(mix_out), 32'h7F);

      // mute and snapshot
      wr(8'hF8, 8'h8F);
      send_tick(1);
      drain();
      chk("mute", 32'(mix_out), 32'h00);
      rd("rb_f8", 8'hF8, 1'b0, 8'h8F);
      send_tick(1);
      step();
      wr(8'hF8, 8'h0F);
      drain();
      chk("snap_old", 32'(mix_out), 32'h00);
      send_tick(1);
      drain();
      chk("snap_new", 32'(mix_out), 32'hEF);

      // overrun
      ch_in = {8'h00, 8'h00, 8'h40, 8'h40};
      model_reset();
      for (int i = 0; i < 4; i++) wr(8'hF8 + 8'(i), 8'h0F);
      nv = nvalid;
      send_tick(1);
      step();
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      drain();
      repeat (4) step();
      chk("ovr_one", 32'(nvalid - nv), 32'd1);
      rd("ovr_set", 8'hFC, 1'b0, 8'h01);
      wr(8'hFC, 8'h00);
      rd("ovr_clr", 8'hFC, 1'b0, 8'h00);
      send_tick(1);
      step();
      sample_tick     = 1'b1;
      bus.zxuno_addr  = 8'hFC;
      bus.zxuno_regwr = 1'b1;
      step();
      sample_tick     = 1'b0;
      bus.zxuno_regwr = 1'b0;
      drain();
      rd("ovr_race", 8'hFC, 1'b0, 8'h01);
      wr(8'hFC, 8'h00);

      // back-to-back: tick at E(NCHAN+2) is accepted
      send_tick(1);
      repeat (5) step();
      send_tick(1);
      drain();
      rd("b2b_st", 8'hFC, 1'b0, 8'h00);

      // sigma-delta density
      wr(8'hF8, 8'h08);
      wr(8'hF9, 8'h08);
      ch_in = {8'h00, 8'h00, 8'h80, 8'h80};
      send_tick(1);
      drain();
      chk("sd_mix80", 32'(mix_out), 32'h80);
      count_ones("sd_80", 128);
      ch_in = '0;
      send_tick(1);
      drain();
      count_ones("sd_00", 0);
      model_reset();
      for (int i = 0; i < 4; i++) wr(8'hF8 + 8'(i), 8'h0F);
      ch_in = 32'hFFFF_FFFF;
      send_tick(1);
      drain();
      count_ones("sd_ff", 255);

      // reset mid-frame
      wr(8'hF9, 8'h83);
      nv = nvalid;
      send_tick(0);
      step();
      step();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      model_reset();
      repeat (10) step();
      chk("mrst_val", 32'(nvalid - nv), 32'd0);
      chk("mrst_mix", 32'(mix_out), 32'h00);
      chk("mrst_aud", 32'(audio_out), 32'd0);
      rd("mrst_f9", 8'hF9, 1'b0, 8'h0F);

      chk("q_empty", 32'(q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
